// File: rtl/npc_fetch_ctrl_if.sv
// npc_fetch_ctrl_if
// Groups the instruction-memory, redirect and decode handshakes of the
// fetch controller into one bundle.
//   imem_req/imem_addr   : read request and word-aligned address to memory
//   imem_ack/imem_rdata  : memory accept/return strobe and instruction word
//   br_valid/br_target   : redirect request from execute and its target
//   inst_valid/inst/inst_pc/inst_ready : queue head offered to decode
// master is the fetch controller side, slave is the memory/execute/decode side.
interface npc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        br_valid;
  logic [31:0] br_target;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, br_valid, br_target, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, br_valid, br_target, inst_ready
  );
endinterface

// File: rtl/npc_fetch_ctrl.sv
// npc_fetch_ctrl
// Fetch controller sitting after the PC register. It reads instruction
// memory at the registered pc, buffers returned words in a 2-entry queue
// for decode and produces npc, which the PC register loads every edge.
// Stalls hold npc = pc; redirects drive npc = br_target (word aligned).
// Ports:
//   clk   : clock, all state updates on posedge
//   rst_n : synchronous active-low reset
//   pc    : current PC from the PC register
//   npc   : next PC for the PC register
//   bus   : memory / redirect / decode handshakes (master modport)
module npc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc,
  output logic [31:0]      npc,
  npc_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {BOOT, FETCH, DRAIN} state_t;

  state_t      state, state_next;
  logic [1:0]  count;
  logic [31:0] slot0_word, slot0_pc;
  logic [31:0] slot1_word, slot1_pc;
  logic        req_pend;
  logic [31:0] drain_addr;
  logic        fetch_req;
  logic        push, pop, flush, latch_drain;
  logic [31:0] target;
  logic [31:0] pc_word;

  assign target  = bus.br_target & ~32'h3;
  assign pc_word = pc & ~32'h3;

  // Queue head is presented straight from registers, so decode never sees
  // a combinational path from imem_rdata.
  assign bus.inst_valid = (count != 2'd0);
  assign bus.inst       = slot0_word;
  assign bus.inst_pc    = slot0_pc;

  always_comb begin
    state_next  = state;
    npc         = pc;
    fetch_req   = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
    latch_drain = 1'b0;
    bus.imem_req  = 1'b0;
    bus.imem_addr = pc_word;
    case (state)
      BOOT: begin
        npc        = RESET_PC;
        state_next = FETCH;
      end
      FETCH: begin
        if (bus.br_valid) begin
          npc   = target;
          flush = 1'b1;
          // A request left unacknowledged last cycle is still owned by the
          // memory; it must be completed (and its data dropped) in DRAIN.
          if (req_pend) begin
            latch_drain = 1'b1;
            state_next  = DRAIN;
          end
        end else begin
          // Request gating uses the registered count, so a pop while full
          // only re-enables fetching on the following cycle.
          fetch_req    = (count != 2'd2);
          bus.imem_req = fetch_req;
          pop          = bus.inst_valid & bus.inst_ready;
          if (fetch_req && bus.imem_ack) begin
            push = 1'b1;
            npc  = pc + 32'd4;
          end
        end
      end
      DRAIN: begin
        bus.imem_req  = 1'b1;
        bus.imem_addr = drain_addr;
        if (bus.br_valid) begin
          npc = target;
        end
        // The abandoned transfer finishing ends the drain even if a new
        // redirect arrives alongside it; the redirect still steers npc.
        if (bus.imem_ack) begin
          state_next = FETCH;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BOOT;
      count      <= 2'd0;
      slot0_word <= 32'h0;
      slot0_pc   <= 32'h0;
      slot1_word <= 32'h0;
      slot1_pc   <= 32'h0;
      req_pend   <= 1'b0;
      drain_addr <= 32'h0;
    end else begin
      state    <= state_next;
      req_pend <= bus.imem_req & ~bus.imem_ack;
      if (latch_drain) begin
        drain_addr <= pc_word;
      end
      if (flush) begin
        count <= 2'd0;
      end else begin
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              slot0_word <= bus.imem_rdata;
              slot0_pc   <= pc_word;
            end else begin
              slot1_word <= bus.imem_rdata;
              slot1_pc   <= pc_word;
            end
            count <= count + 2'd1;
          end
          2'b01: begin
            slot0_word <= slot1_word;
            slot0_pc   <= slot1_pc;
            count      <= count - 2'd1;
          end
          2'b11: begin
            // Push only happens below full, so count is 1 here: the new
            // word directly replaces the departing head.
            slot0_word <= bus.imem_rdata;
            slot0_pc   <= pc_word;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_npc_fetch_ctrl.sv
// tb_npc_fetch_ctrl
// Self-checking bench for npc_fetch_ctrl: directed scenarios followed by a
// randomized phase, all compared against a transaction-level reference
// model (instruction queue, boot/drain flags, model PC).
module tb_npc_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [31:0] npc;

  npc_fetch_ctrl_if bus ();

  npc_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pc    (pc),
    .npc   (npc),
    .bus   (bus)
  );

  // Clock generation
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The PC register in front of the controller loads npc on every edge
  always_ff @(posedge clk) pc <= npc;

  // Memory model: contents are a fixed function of the address; acks are
  // either random per cycle or come after mem_wait unacknowledged cycles
  int   mem_wait;
  int   wait_cnt;
  bit   rand_mode;
  bit   ack_rand;
  logic ack_allow;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  always_comb ack_allow = rand_mode ? ack_rand : (wait_cnt >= mem_wait);
  assign bus.imem_ack   = bus.imem_req & ack_allow;
  assign bus.imem_rdata = mem_word(bus.imem_addr);

  always_ff @(posedge clk) begin
    if (!rst_n || (bus.imem_req && bus.imem_ack)) wait_cnt <= 0;
    else if (bus.imem_req)                          wait_cnt <= wait_cnt + 1;
  end

  // Reference model
  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
  } entry_t;

  entry_t      q[$];
  bit          m_known, m_boot, m_drain, m_out;
  logic [31:0] m_pc, m_drain_addr;
  logic [31:0] e_npc, e_addr;
  bit          e_req, e_hs;

  int checks;
  int failures;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit br, input logic [31:0] tgt, input bit rdy);
    rst_n         = r;
    bus.br_valid  = br;
    bus.br_target = tgt;
    bus.inst_ready = rdy;
    ack_rand      = 1'($urandom_range(0, 1));
  endtask

  // Predict this cycle's outputs from the model and compare at the negedge
  task automatic modelCheck();
    logic [31:0] tgt;
    @(negedge clk);
    if (!m_known) return;
    tgt  = bus.br_target & ~32'h3;
    e_hs = 1'b0;
    if (m_boot) begin
      e_req  = 1'b0;
      e_addr = m_pc;
      e_npc  = RESET_PC;
    end else if (m_drain) begin
      e_req  = 1'b1;
      e_addr = m_drain_addr;
      e_hs   = ack_allow;
      e_npc  = bus.br_valid ? tgt : m_pc;
    end else begin
      e_req  = (q.size() < 2) && !bus.br_valid;
      e_addr = m_pc;
      e_hs   = e_req && ack_allow;
      e_npc  = bus.br_valid ? tgt : (e_hs ? m_pc + 32'd4 : m_pc);
    end
    checkOutput("model_npc", npc, e_npc);
    checkOutput("model_req", 32'(bus.imem_req), 32'(e_req));
    if (e_req) checkOutput("model_addr", bus.imem_addr, e_addr);
    checkOutput("model_valid", 32'(bus.inst_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      checkOutput("model_inst", bus.inst, q[0].word);
      checkOutput("model_inst_pc", bus.inst_pc, q[0].addr);
    end
  endtask

  // Advance the model across the clock edge
  task automatic commit();
    if (!rst_n) begin
      q.delete();
      m_known = 1'b1;
      m_boot  = 1'b1;
      m_drain = 1'b0;
      m_out   = 1'b0;
      m_pc    = RESET_PC;
    end else if (m_known) begin
      if (m_boot) begin
        m_boot = 1'b0;
      end else if (m_drain) begin
        if (e_hs) m_drain = 1'b0;
      end else if (bus.br_valid) begin
        q.delete();
        if (m_out) begin
          m_drain      = 1'b1;
          m_drain_addr = m_pc;
        end
      end else begin
        if (q.size() != 0 && bus.inst_ready) void'(q.pop_front());
        if (e_hs) q.push_back({mem_word(m_pc), m_pc});
      end
      m_out = e_req && !e_hs;
      m_pc  = e_npc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input bit r, input bit br, input logic [31:0] tgt, input bit rdy);
    applyStimulus(r, br, tgt, rdy);
    modelCheck();
    commit();
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    m_known   = 1'b0;
    m_boot    = 1'b0;
    m_drain   = 1'b0;
    m_out     = 1'b0;
    m_pc      = 32'h0;
    rand_mode = 1'b0;
    mem_wait  = 0;
    ack_rand  = 1'b0;

    $display("[TB] scenario 1: boot and zero-wait fetch");
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    modelCheck();
    checkOutput("boot_npc", npc, RESET_PC);
    checkOutput("boot_req", 32'(bus.imem_req), 32'h0);
    checkOutput("boot_valid", 32'(bus.inst_valid), 32'h0);
    checkOutput("boot_inst", bus.inst, 32'h0);
    checkOutput("boot_inst_pc", bus.inst_pc, 32'h0);
    commit();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      modelCheck();
      checkOutput("seq_addr", bus.imem_addr, 32'(k * 4));
      if (k > 0) checkOutput("seq_inst_pc", bus.inst_pc, 32'((k - 1) * 4));
      commit();
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    modelCheck();
    checkOutput("seq_inst_pc_last", bus.inst_pc, 32'hC);
    checkOutput("seq_inst_last", bus.inst, mem_word(32'hC));
    commit();

    $display("[TB] scenario 2: decode backpressure");
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    modelCheck();
    checkOutput("full_req", 32'(bus.imem_req), 32'h0);
    checkOutput("full_npc", npc, 32'h8);
    checkOutput("full_inst_pc", bus.inst_pc, 32'h0);
    commit();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    modelCheck();
    checkOutput("pop_full_req", 32'(bus.imem_req), 32'h0);
    commit();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    modelCheck();
    checkOutput("resume_req", 32'(bus.imem_req), 32'h1);
    checkOutput("resume_addr", bus.imem_addr, 32'h8);
    checkOutput("resume_inst_pc", bus.inst_pc, 32'h4);
    commit();
    cycle(1'b1, 1'b0, 32'h0, 1'b1);

    $display("[TB] scenario 3: wait-state memory");
    mem_wait = 3;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      modelCheck();
      checkOutput("wait_addr", bus.imem_addr, 32'h10);
      checkOutput("wait_npc", npc, 32'h10);
      commit();
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    modelCheck();
    checkOutput("wait_ack_npc", npc, 32'h14);
    commit();

    $display("[TB] scenario 4: redirect with full queue");
    mem_wait = 0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    modelCheck();
    checkOutput("wait_inst_pc", bus.inst_pc, 32'h10);
    commit();
    applyStimulus(1'b1, 1'b1, 32'h103, 1'b1);
    modelCheck();
    checkOutput("br_npc", npc, 32'h100);
    checkOutput("br_valid_before", 32'(bus.inst_valid), 32'h1);
    commit();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    modelCheck();
    checkOutput("br_flushed", 32'(bus.inst_valid), 32'h0);
    checkOutput("br_addr", bus.imem_addr, 32'h100);
    commit();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    modelCheck();
    checkOutput("br_inst_pc", bus.inst_pc, 32'h100);
    commit();

    $display("[TB] scenario 5: redirect during wait-state request");
    cycle(1'b1, 1'b1, 32'h20, 1'b1);
    mem_wait = 5;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    modelCheck();
    checkOutput("d_wait_addr", bus.imem_addr, 32'h20);
    commit();
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b1);
    modelCheck();
    checkOutput("d_br_npc", npc, 32'h200);
    commit();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    modelCheck();
    checkOutput("d_drain_req", 32'(bus.imem_req), 32'h1);
    checkOutput("d_drain_addr", bus.imem_addr, 32'h20);
    checkOutput("d_drain_npc", npc, 32'h200);
    commit();
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b1);
    modelCheck();
    checkOutput("d_br2_npc", npc, 32'h300);
    checkOutput("d_br2_addr", bus.imem_addr, 32'h20);
    commit();
    mem_wait = 0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    modelCheck();
    checkOutput("d_ack_addr", bus.imem_addr, 32'h20);
    checkOutput("d_ack_npc", npc, 32'h300);
    commit();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    modelCheck();
    checkOutput("d_fetch_addr", bus.imem_addr, 32'h300);
    checkOutput("d_dropped", 32'(bus.inst_valid), 32'h0);
    commit();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    modelCheck();
    checkOutput("d_first_inst_pc", bus.inst_pc, 32'h300);
    commit();

    $display("[TB] scenario 6: address wrap and reset mid-fetch");
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    modelCheck();
    checkOutput("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    checkOutput("wrap_npc", npc, 32'h0);
    commit();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    modelCheck();
    checkOutput("wrap_next_addr", bus.imem_addr, 32'h0);
    checkOutput("wrap_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
    commit();
    mem_wait = 4;
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    modelCheck();
    checkOutput("rst_pending_req", 32'(bus.imem_req), 32'h1);
    commit();
    mem_wait = 0;
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    modelCheck();
    checkOutput("rst_req", 32'(bus.imem_req), 32'h0);
    checkOutput("rst_valid", 32'(bus.inst_valid), 32'h0);
    checkOutput("rst_npc", npc, RESET_PC);
    commit();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    modelCheck();
    checkOutput("rst_fetch_req", 32'(bus.imem_req), 32'h1);
    checkOutput("rst_fetch_addr", bus.imem_addr, RESET_PC);
    commit();

    $display("[TB] scenario 7: randomized traffic");
    rand_mode = 1'b1;
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) == 0),
            32'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/npc_fetch_ctrl.md
Name: npc_fetch_ctrl

Overview:
Front-end fetch controller on the far side of the PC register. It consumes the registered PC, issues instruction-memory reads at that address, and buffers returned words for decode in a 2-entry queue. It computes npc, the next-PC value the PC register loads unconditionally on every clk edge. Stalls are expressed as npc = pc, and branch redirects as npc = br_target.

Parameters:
RESET_PC, 32'h0000_0000, value driven on npc while in BOOT; first fetch address.

Ports:
clk  input  1  system clock, all state on posedge
rst_n  input  1  synchronous, active-low reset
pc  input  32  current PC from the PC register
npc  output  32  next PC; PC register loads it every edge
imem_req  output  1  read request to instruction memory
imem_addr  output  32  read address, word aligned
imem_ack  input  1  memory accepts/returns this cycle; may be combinational from imem_req
imem_rdata  input  32  instruction word, valid when imem_ack=1
br_valid  input  1  redirect request from execute, one-cycle pulse or held
br_target  input  32  redirect target; bits [1:0] ignored, treated as 00
inst_valid  output  1  head of queue valid
inst  output  32  head instruction word
inst_pc  output  32  address of head instruction
inst_ready  input  1  decode consumes head when inst_valid & inst_ready

Behaviour:
- Reset: the rst_n=0 sampled at posedge clears everything. Resulting state:
  - state=BOOT, queue count=0, inst_valid=0, imem_req=0.
  - npc=RESET_PC, inst/inst_pc=0.
  - Reset overrides every in-flight transaction; a pending memory transfer is abandoned.
- FSM states: BOOT, FETCH, DRAIN.
- BOOT:
  - Outputs: imem_req=0, npc=RESET_PC.
  - Transitions to FETCH unconditionally on the next edge.
  - The PC therefore holds RESET_PC when FETCH starts.
- FETCH request:
  - imem_req=1 iff count<2 and br_valid=0; imem_addr=pc.
  - The request is held with a constant address until imem_ack. Since npc=pc during the wait, pc itself holds.
- FETCH acknowledge (imem_req & imem_ack):
  - Pushes {imem_rdata, pc} into the queue.
  - npc=pc+4, modulo 2^32, wrapping FFFF_FFFC -> 0000_0000.
- FETCH otherwise: npc=pc.
- Throughput: with zero-wait memory and decode always ready, one instruction per cycle. Fetch-to-inst_valid latency is 1 cycle after the ack edge.
- Queue:
  - 2-entry FIFO with push and pop allowed in the same cycle, leaving count unchanged.
  - Pop on an empty queue is impossible because inst_valid=0.
  - Full (count=2) deasserts imem_req. A pop in that same cycle does not re-enable the request until the next cycle.
  - Order is preserved.
- Redirect (br_valid=1), highest priority in FETCH and DRAIN:
  - npc=br_target with [1:0]=00.
  - Queue is flushed, so count=0 after the edge. A same-cycle pop is ignored and a same-cycle push is discarded.
  - If imem_req was high last cycle and no ack has arrived yet, the old address is latched into a drain register and the FSM enters DRAIN. Otherwise it stays in FETCH.
- DRAIN:
  - imem_req=1, imem_addr=drain address (old request honoured).
  - imem_ack discards the data; no push occurs.
  - Next state on ack is FETCH, with npc=pc (the target) during the wait.
  - A second br_valid in DRAIN updates npc to the new target and stays in DRAIN.
- Outputs inst, inst_pc and inst_valid are registered queue-head values; they carry no combinational path from imem_rdata.
- imem_addr[1:0] is always 00.

Test Plan:
1. Reset release, zero-wait memory (ack=1 always), inst_ready=1, RESET_PC=0:
   - Boot: npc=0 during BOOT.
   - Fetch addresses 0,4,8,C on consecutive cycles.
   - inst_pc 0,4,8,C one cycle later, with inst matching the memory model.
2. Backpressure, inst_ready=0 from the start:
   - Two words queued (inst_pc 0, 4), then imem_req=0 and npc=pc=8 held.
   - Raising inst_ready pops 0, and fetching resumes at 8 the following cycle.
3. Wait-state memory, ack 3 cycles after req:
   - imem_addr stays at 0x10 and pc stays 0x10 for all 3 cycles.
   - After ack: npc=0x14, inst_pc=0x10.
4. Redirect with no pending request:
   - Queue holds 2 entries and br_valid=1 with br_target=0x103.
   - Response: queue empties, npc=0x100, next fetch at 0x100, first inst_pc=0x100.
5. Redirect during wait-state request at 0x20:
   - FSM enters DRAIN and imem_addr stays 0x20 until ack.
   - The 0x20 data is dropped; next request is at the target 0x200.
   - A second br_valid(0x300) during DRAIN results in the fetch going to 0x300.
6. Edge cases:
   - Wrap: pc=FFFF_FFFC with ack gives npc=0000_0000.
   - Reset mid-fetch: rst_n=0 while imem_req=1 gives imem_req=0, inst_valid=0 and npc=RESET_PC after the edge, followed by BOOT then FETCH at RESET_PC.
